spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
Parametrised SPI slave, successor to the fixed 8-bit mode-0 slave. All SPI pins are synchronised into the single system clock domain, so rx and tx logic run on `clk` only. Configurable word width, bit order and CPOL/CPHA mode. Valid/ready tx handshake, pulsed rx_valid, and clean abort when cs is deasserted mid-word. Sits between the board SPI pins and a register file or FIFO.

Parameters:
DATA_WIDTH  8  bits per SPI word (>=2)
CPOL  0  idle level of spi_clk
CPHA  0  0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST  1  1 = MSB shifted first on both mosi and miso; 0 = LSB first
SYNC_STAGES  2  synchroniser depth for spi_clk, cs and mosi (>=2)

Ports:
clk  in  1  system clock; must be >= 4x spi_clk frequency
reset  in  1  asynchronous, active-high reset
spi_clk  in  1  SPI serial clock from master
cs  in  1  chip select, active low
mosi  in  1  master-out data
miso  out  1  slave-out data
miso_oe  out  1  miso output enable; high only while selected
tx_data  in  DATA_WIDTH  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  one-cycle pulse: tx word loaded this cycle
rx_data  out  DATA_WIDTH  last complete received word; held until the next word completes
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high while in ACTIVE

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is asynchronous and active-high. While reset is high: all state is cleared, state=IDLE, miso=0, miso_oe=0, tx_ready=0, rx_valid=0, busy=0, rx_data=0.
- Synchronisation: spi_clk, cs and mosi each pass through SYNC_STAGES flops.
- Edge detection: compare the synchronised spi_clk with its previous value.
  - Leading edge = transition away from CPOL. Trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- State machine, IDLE:
  - On a synchronised cs falling edge, go to ACTIVE, clear bit_cnt and load_pending, and perform a tx load.
- State machine, ACTIVE:
  - On a synchronised cs rising edge, go to IDLE, discard the partial rx word, do not pulse rx_valid, and set miso_oe=0.
- tx load:
  - tx_ready=1 for exactly that cycle.
  - If tx_valid=1, the tx shift register takes tx_data. Otherwise it takes all zeros (underrun).
  - The handshake completes only in the tx_ready && tx_valid cycle.
- miso: always the current output bit of the tx shift register (MSB if MSB_FIRST, else LSB). miso_oe=busy.
- Sample edge, in ACTIVE:
  - Shift the synchronised mosi into the rx shift register.
  - If bit_cnt==DATA_WIDTH-1: rx_data <= completed word, rx_valid=1 next cycle, bit_cnt <= 0, load_pending <= 1.
  - Otherwise bit_cnt++.
- Shift edge, in ACTIVE:
  - If load_pending: tx load, then clear load_pending.
  - Else if bit_cnt!=0: shift tx by one bit.
  - Else: no action. This covers the first leading edge when CPHA=1.
- Back-to-back words: the next word loads on the first shift edge after the last sample, with no idle bit. The first bit is on miso before the master samples it.
- Latency: rx_valid fires SYNC_STAGES+1 clk cycles after the raw final sample edge.
- Simultaneous events: a cs rising edge in the same cycle as a sample edge is treated as an abort; the sample is ignored.
- spi_clk edges while cs is high are ignored.
- Reset asserted mid-word: immediate clear, no rx_valid.

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- When defined, three ports are added:
  - status_clr (in, 1): clears both flags on the next clk edge. A concurrent set takes priority over the clear.
  - underrun (out, 1): sticky; set on any tx load with tx_valid=0.
  - abort (out, 1): sticky; set when cs rises with bit_cnt!=0.
- Both flags reset to 0.
- When not defined: these ports do not exist; underruns send zeros silently and aborts are silent.

Test Plan:
- CPOL=0, CPHA=0, 8-bit: tx_data=0x3C with tx_valid held, master sends 0xA5 -> master receives 0x3C; rx_data=0xA5; exactly one rx_valid pulse; one tx_ready pulse at cs fall.
- CPOL=1, CPHA=1, MSB_FIRST=0, DATA_WIDTH=16: master sends 0x1234, slave tx 0xBEEF -> rx_data=0x1234; master receives 0xBEEF; bits on the wire LSB first.
- Two back-to-back words under one cs, tx 0x11 then 0x22, master sends 0x55 then 0xAA -> two rx_valid pulses (0x55, then 0xAA); master receives 0x11, then 0x22; two tx_ready pulses.
- tx_valid=0 at cs fall -> master receives 0x00. With SPI_SLAVE_STATUS_EN: underrun=1 until status_clr.
- cs raised after 3 bits, then a full new transfer of 0x0F -> no rx_valid for the partial word; next rx_data=0x0F. With SPI_SLAVE_STATUS_EN: abort=1.
- reset pulsed mid-word -> miso=0, miso_oe=0, rx_data=0 immediately; the following transfer works normally.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave with configurable word width, bit order and CPOL/CPHA; all pins are resampled on clk.
// Define SPI_SLAVE_STATUS_EN to add sticky underrun/abort flags and a status_clr input.
module spi_slave_param #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic                  status_clr,
  output logic                  underrun,
  output logic                  abort
`endif
);

  localparam int unsigned CNT_W       = $clog2(DATA_WIDTH);
  localparam logic        IDLE_LVL    = 1'(CPOL);
  localparam bit          SAMPLE_LEAD = (CPHA == 0);
  localparam bit          MSB_FIRST_B = (MSB_FIRST != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchronisers; the extra top bit of sclk/cs holds the previous synchronised value.
  logic [SYNC_STAGES:0]   sclk_sr;
  logic [SYNC_STAGES:0]   cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   load_pending_q, load_pending_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_d;
  logic                   rx_valid_d;
  logic                   tx_load;

  logic                   sclk_s, sclk_p, cs_s, cs_p, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   cs_fall, cs_rise;
  logic [DATA_WIDTH-1:0]  rx_next, tx_shifted;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign sclk_p = sclk_sr[SYNC_STAGES];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign cs_p   = cs_sr[SYNC_STAGES];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign lead_edge   = (sclk_p == IDLE_LVL) && (sclk_s != IDLE_LVL);
  assign trail_edge  = (sclk_p != IDLE_LVL) && (sclk_s == IDLE_LVL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
  assign cs_fall     = cs_p & ~cs_s;
  assign cs_rise     = ~cs_p & cs_s;

  assign rx_next    = MSB_FIRST_B ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shifted = MSB_FIRST_B ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};

  assign miso     = MSB_FIRST_B ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0];
  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign tx_ready = tx_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr <= {(SYNC_STAGES+1){IDLE_LVL}};
      cs_sr   <= '1;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], spi_clk};
      cs_sr   <= {cs_sr[SYNC_STAGES-1:0], cs};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      load_pending_q <= 1'b0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      load_pending_q <= load_pending_d;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      rx_data        <= rx_data_d;
      rx_valid       <= rx_valid_d;
    end
  end

  // cs rise wins over a coincident sample edge so a truncated word is never delivered.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    load_pending_d = load_pending_q;
    tx_shift_d     = tx_shift_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data;
    rx_valid_d     = 1'b0;
    tx_load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d        = ACTIVE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
          rx_shift_d     = '0;
          tx_load        = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d        = IDLE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
          rx_shift_d     = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            rx_data_d      = rx_next;
            rx_valid_d     = 1'b1;
            bit_cnt_d      = '0;
            load_pending_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          if (load_pending_q) begin
            tx_load        = 1'b1;
            load_pending_d = 1'b0;
          end else if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shifted;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (tx_load) tx_shift_d = tx_valid ? tx_data : '0;
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic abort_set;
  assign abort_set = (state_q == ACTIVE) && cs_rise && (bit_cnt_q != '0);

  // Sticky flags; a set in the same cycle as status_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      if (tx_load && !tx_valid) underrun <= 1'b1;
      else if (status_clr)      underrun <= 1'b0;
      if (abort_set)            abort    <= 1'b1;
      else if (status_clr)      abort    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: a mode-0 8-bit MSB-first instance and a
// mode-3 16-bit LSB-first instance, driven by a bit-banged SPI master.
module tb_spi_slave_param;

  localparam int H = 50;  // SPI half period in ns; clk period is 10 ns

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sclk0, cs0, mosi0, miso0, oe0, txv0, txr0, rxv0, busy0;
  logic [7:0]  txd0, rxd0;
  logic        sclk1, cs1, mosi1, miso1, oe1, txv1, txr1, rxv1, busy1;
  logic [15:0] txd1, rxd1;
`ifdef SPI_SLAVE_STATUS_EN
  logic sclr0, und0, abt0, sclr1, und1, abt1;
`endif

  int checks = 0;
  int errors = 0;

  int rxv_cnt0 = 0, txr_cnt0 = 0, rxv_cnt1 = 0, txr_cnt1 = 0;
  logic [7:0] rx_log0 [$];
  int         txr_at_rxv0 [$];

  spi_slave_param dut0 (
    .clk(clk), .reset(reset), .spi_clk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso0), .miso_oe(oe0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(sclr0), .underrun(und0), .abort(abt0)
`endif
  );

  spi_slave_param #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .spi_clk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso1), .miso_oe(oe1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(sclr1), .underrun(und1), .abort(abt1)
`endif
  );

  always @(negedge clk) begin
    if (txr0) txr_cnt0++;
    if (rxv0) begin
      rx_log0.push_back(rxd0);
      txr_at_rxv0.push_back(txr_cnt0);
      rxv_cnt0++;
    end
    if (txr1) txr_cnt1++;
    if (rxv1) rxv_cnt1++;
  end

  task automatic cs_low(input int sel);
    if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
    #H;
  endtask

  task automatic cs_high(input int sel);
    #H;
    if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
    #(4*H);
  endtask

  // One word (or nbits of it) with cs already low; first4 holds the first 4 miso bits, earliest in [3].
  task automatic xfer(input int sel, input logic [15:0] mo, input int nbits,
                      output logic [15:0] mi, output logic [3:0] first4);
    int b;
    mi = '0;
    first4 = '0;
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) begin
        b = 7 - i;
        mosi0 = mo[b];
        #H;
        sclk0 = 1'b1;
        mi[b] = miso0;
        #H;
        sclk0 = 1'b0;
      end else begin
        b = i;
        sclk1 = 1'b0;
        mosi1 = mo[b];
        #H;
        sclk1 = 1'b1;
        mi[b] = miso1;
        #H;
      end
      if (i < 4) first4[3-i] = mi[b];
    end
  endtask

  task automatic test_reset;
    #20;
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", miso0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL rst_miso_oe: got %b expected 0", oe0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    checks++; if (rxd0 !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rxd0); end
    checks++; if ({rxv0, txr0} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b expected 00", {rxv0, txr0}); end
    checks++; if ({oe1, rxd1} !== 17'h0) begin errors++; $display("FAIL rst_dut1: got %h expected 0", {oe1, rxd1}); end
    #40;
    reset = 1'b0;
    #40;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b expected 0", busy0); end
  endtask

  task automatic test_mode0;
    logic [15:0] mi;
    logic [3:0]  f4;
    int rb, tb0;
    txd0 = 8'h3C; txv0 = 1'b1;
    rb = rxv_cnt0; tb0 = txr_cnt0;
    cs_low(0);
    checks++; if (busy0 !== 1'b1 || oe0 !== 1'b1) begin errors++; $display("FAIL m0_busy_oe: got %b%b expected 11", busy0, oe0); end
    xfer(0, 16'h00A5, 8, mi, f4);
    cs_high(0);
    checks++; if (mi[7:0] !== 8'h3C) begin errors++; $display("FAIL m0_master_rx: got %h expected 3c", mi[7:0]); end
    checks++; if (f4 !== 4'h3) begin errors++; $display("FAIL m0_msb_order: got %h expected 3", f4); end
    checks++; if (rxd0 !== 8'hA5) begin errors++; $display("FAIL m0_rx_data: got %h expected a5", rxd0); end
    checks++; if (rxv_cnt0 - rb !== 1) begin errors++; $display("FAIL m0_rx_valid_cnt: got %0d expected 1", rxv_cnt0 - rb); end
    checks++; if (txr_at_rxv0[rb] - tb0 !== 1) begin errors++; $display("FAIL m0_tx_ready_cnt: got %0d expected 1", txr_at_rxv0[rb] - tb0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL m0_oe_after_cs: got %b expected 0", oe0); end
  endtask

  task automatic test_mode3_lsb16;
    logic [15:0] mi;
    logic [3:0]  f4;
    int rb, tb1;
    txd1 = 16'hBEEF; txv1 = 1'b1;
    rb = rxv_cnt1; tb1 = txr_cnt1;
    cs_low(1);
    xfer(1, 16'h1234, 16, mi, f4);
    cs_high(1);
    checks++; if (mi !== 16'hBEEF) begin errors++; $display("FAIL m3_master_rx: got %h expected beef", mi); end
    checks++; if (f4 !== 4'hF) begin errors++; $display("FAIL m3_lsb_order: got %h expected f", f4); end
    checks++; if (rxd1 !== 16'h1234) begin errors++; $display("FAIL m3_rx_data: got %h expected 1234", rxd1); end
    checks++; if (rxv_cnt1 - rb !== 1) begin errors++; $display("FAIL m3_rx_valid_cnt: got %0d expected 1", rxv_cnt1 - rb); end
    checks++; if (txr_cnt1 - tb1 !== 1) begin errors++; $display("FAIL m3_tx_ready_cnt: got %0d expected 1", txr_cnt1 - tb1); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ma, mb;
    logic [3:0]  f4;
    int rb, tb0;
    txd0 = 8'h11; txv0 = 1'b1;
    rb = rxv_cnt0; tb0 = txr_cnt0;
    cs_low(0);
    txd0 = 8'h22;
    xfer(0, 16'h0055, 8, ma, f4);
    xfer(0, 16'h00AA, 8, mb, f4);
    cs_high(0);
    checks++; if (ma[7:0] !== 8'h11) begin errors++; $display("FAIL b2b_master_rx0: got %h expected 11", ma[7:0]); end
    checks++; if (mb[7:0] !== 8'h22) begin errors++; $display("FAIL b2b_master_rx1: got %h expected 22", mb[7:0]); end
    checks++; if (rxv_cnt0 - rb !== 2) begin errors++; $display("FAIL b2b_rx_valid_cnt: got %0d expected 2", rxv_cnt0 - rb); end
    checks++; if (rx_log0[rb] !== 8'h55) begin errors++; $display("FAIL b2b_rx0: got %h expected 55", rx_log0[rb]); end
    checks++; if (rx_log0[rb+1] !== 8'hAA) begin errors++; $display("FAIL b2b_rx1: got %h expected aa", rx_log0[rb+1]); end
    checks++; if (txr_at_rxv0[rb+1] - tb0 !== 2) begin errors++; $display("FAIL b2b_tx_ready_cnt: got %0d expected 2", txr_at_rxv0[rb+1] - tb0); end
  endtask

  task automatic test_underrun;
    logic [15:0] mi;
    logic [3:0]  f4;
    txd0 = 8'hFF; txv0 = 1'b0;
    cs_low(0);
    xfer(0, 16'h0096, 8, mi, f4);
    cs_high(0);
    txv0 = 1'b1;
    checks++; if (mi[7:0] !== 8'h00) begin errors++; $display("FAIL ur_master_rx: got %h expected 00", mi[7:0]); end
    checks++; if (rxd0 !== 8'h96) begin errors++; $display("FAIL ur_rx_data: got %h expected 96", rxd0); end
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if (und0 !== 1'b1) begin errors++; $display("FAIL ur_flag_set: got %b expected 1", und0); end
    sclr0 = 1'b1; #10; sclr0 = 1'b0; #10;
    checks++; if (und0 !== 1'b0) begin errors++; $display("FAIL ur_flag_clr: got %b expected 0", und0); end
`endif
  endtask

  task automatic test_abort;
    logic [15:0] mi;
    logic [3:0]  f4;
    int rb;
`ifdef SPI_SLAVE_STATUS_EN
    sclr0 = 1'b1; #10; sclr0 = 1'b0; #10;
    checks++; if (abt0 !== 1'b0) begin errors++; $display("FAIL ab_flag_idle: got %b expected 0", abt0); end
`endif
    txd0 = 8'hF0; txv0 = 1'b1;
    rb = rxv_cnt0;
    cs_low(0);
    xfer(0, 16'h00E0, 3, mi, f4);
    cs_high(0);
    checks++; if (rxv_cnt0 !== rb) begin errors++; $display("FAIL ab_no_rx_valid: got %0d expected %0d", rxv_cnt0, rb); end
    checks++; if (rxd0 !== 8'h96) begin errors++; $display("FAIL ab_rx_held: got %h expected 96", rxd0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b expected 0", busy0); end
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if (abt0 !== 1'b1) begin errors++; $display("FAIL ab_flag_set: got %b expected 1", abt0); end
`endif
    txd0 = 8'h81;
    cs_low(0);
    xfer(0, 16'h000F, 8, mi, f4);
    cs_high(0);
    checks++; if (rxd0 !== 8'h0F) begin errors++; $display("FAIL ab_next_rx: got %h expected 0f", rxd0); end
    checks++; if (mi[7:0] !== 8'h81) begin errors++; $display("FAIL ab_next_master_rx: got %h expected 81", mi[7:0]); end
    checks++; if (rxv_cnt0 - rb !== 1) begin errors++; $display("FAIL ab_rx_valid_cnt: got %0d expected 1", rxv_cnt0 - rb); end
  endtask

  task automatic test_reset_mid_word;
    logic [15:0] mi;
    logic [3:0]  f4;
    int rb;
    txd0 = 8'hFF; txv0 = 1'b1;
    rb = rxv_cnt0;
    cs_low(0);
    xfer(0, 16'h00C0, 5, mi, f4);
    reset = 1'b1;
    #1;
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL mid_rst_miso: got %b expected 0", miso0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL mid_rst_oe: got %b expected 0", oe0); end
    checks++; if (rxd0 !== 8'h00) begin errors++; $display("FAIL mid_rst_rx_data: got %h expected 00", rxd0); end
    #9;
    cs0 = 1'b1; sclk0 = 1'b0;
    #40;
    reset = 1'b0;
    #100;
    txd0 = 8'hC3;
    cs_low(0);
    xfer(0, 16'h005A, 8, mi, f4);
    cs_high(0);
    checks++; if (mi[7:0] !== 8'hC3) begin errors++; $display("FAIL post_rst_master_rx: got %h expected c3", mi[7:0]); end
    checks++; if (rxd0 !== 8'h5A) begin errors++; $display("FAIL post_rst_rx_data: got %h expected 5a", rxd0); end
    checks++; if (rxv_cnt0 - rb !== 1) begin errors++; $display("FAIL post_rst_rx_valid_cnt: got %0d expected 1", rxv_cnt0 - rb); end
  endtask

  initial begin
    reset = 1'b1;
    cs0 = 1'b1; sclk0 = 1'b0; mosi0 = 1'b0; txd0 = '0; txv0 = 1'b0;
    cs1 = 1'b1; sclk1 = 1'b1; mosi1 = 1'b0; txd1 = '0; txv1 = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    sclr0 = 1'b0; sclr1 = 1'b0;
`endif
    test_reset;
    test_mode0;
    test_mode3_lsb16;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_reset_mid_word;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
